mul64_ap_resp: RTL and testbench
================================

Name: mul64_ap_resp

Overview:
- Callee (responder) side of the ap_ctrl_hs block-level handshake that our top-level HLS controllers use to drive arithmetic sub-cores.
- Accepts two 64-bit operands on ap_start. Computes the low 64 bits of their unsigned product with an iterative radix-2 shift-add datapath.
- Signals completion with single-cycle ap_done/ap_ready pulses and holds the result on ap_return.
- The FSM carries the same working_key transition locking as the rest of the locked design. With the correct key, behaviour is purely functional.

Parameters:
- ITERS, 64, number of shift-add iterations; equals the operand width. Fixed at 64 for this revision.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst_n  in  1  synchronous reset, active-low.
- ap_start  in  1  request from the caller; sampled only in IDLE.
- ap_done  out  1  one-cycle pulse in DONE.
- ap_idle  out  1  high in IDLE when ap_start=0.
- ap_ready  out  1  one-cycle pulse in DONE, coincident with ap_done.
- a  in  64  multiplicand; sampled when the start is accepted.
- b  in  64  multiplier; sampled when the start is accepted.
- ap_return  out  64  low 64 bits of a*b; registered and held until the next DONE.
- working_key  in  64  locking key; correct key is all zeros.

Behaviour:
- Reset: ap_rst_n=0 at a rising edge forces the following, regardless of current state:
  - FSM to IDLE, one-hot 4'b0001.
  - acc, a_sh, b_sh, cnt and ap_return to 0.
  - ap_done, ap_ready and ap_idle follow the combinational rules below.
- States are one-hot: IDLE, CALC, DONE, HOLD. HOLD is reachable only with a wrong key.
- IDLE:
  - ap_idle = ~ap_start.
  - On ap_start=1: a_sh<=a, b_sh<=b, acc<=0, cnt<=0, then go to CALC.
  - Otherwise stay in IDLE.
- CALC, one iteration per cycle:
  - If b_sh[0]=1, acc<=acc+a_sh, wrapping mod 2^64.
  - a_sh<=a_sh<<1 and b_sh<=b_sh>>1, both with zero fill.
  - cnt<=cnt+1, 7-bit counter.
  - When cnt=ITERS-1, go to DONE with ap_return<=final acc, i.e. the acc value including this cycle's add.
- Latency: the start is accepted at edge T0. There are ITERS CALC cycles, then DONE. ap_done is high during the cycle after edge T0+ITERS, i.e. 65 cycles after acceptance.
- DONE:
  - ap_done=ap_ready=1 for exactly one cycle.
  - ap_return is already valid in this cycle.
  - Next state is IDLE unconditionally, so ap_start is never accepted in DONE.
  - A held-high ap_start is accepted again in the IDLE cycle that follows. Minimum period between accepted starts is 66 cycles.
- Operand changes on a/b after acceptance are ignored.
- ap_start pulses outside IDLE are ignored, with no queuing.
- ap_return holds its last value through IDLE and CALC. It changes only at the entry to DONE, or on reset.
- Reset mid-CALC: the current operation is abandoned, no ap_done is produced, and ap_return returns to 0.
- Locking transitions (all inactive when working_key=0):
  - IDLE with ap_start=1, working_key[0]=1 and a[1:0]=2'b11: go directly to DONE. ap_return<=0 (acc reset value).
  - CALC with working_key[1]=1 and b_sh[3:2]=2'b11: skip this cycle's add; shift and count still occur.
  - CALC exit with working_key[2]=1 and acc[5:4]=2'b11: go to HOLD instead of DONE.
  - HOLD: all outputs low except ap_idle=0; leave HOLD only on reset.
- Only working_key[2:0] are used. Bits [63:3] must not alter behaviour.
- Outputs ap_done, ap_ready and ap_idle are combinational from state and ap_start. ap_return comes from a register.

Test Plan:
- Key=0, a=3, b=5, one-cycle ap_start in IDLE -> ap_done=ap_ready=1 exactly 65 cycles later, single cycle; ap_return=0xF, held through the following IDLE.
- Key=0, a=0xFFFF_FFFF_FFFF_FFFF, b=2 -> ap_return=0xFFFF_FFFF_FFFF_FFFE. Then a=2^63, b=2 -> ap_return=0 (wrap).
- Key=0, ap_start held high with a=7, b=9 constant -> ap_done pulses every 66 cycles, ap_return=63 each time, ap_idle stays 0. Changing a to 1 at cycle 10 does not affect the first result.
- Key=0, ap_rst_n=0 for one edge at cycle 30 of CALC -> FSM in IDLE next cycle, ap_return=0, no ap_done observed; a new start computes correctly.
- Key=1, a=3, b=5 -> ap_done one cycle after acceptance, ap_return=0. The same stimulus with key=0 gives 0xF at 65 cycles.
- Key=4, a=0x30, b=1 -> final acc=0x30 (bits[5:4]=11), FSM enters HOLD, ap_done never asserts, ap_idle=0 until reset.

Source files
------------

// File: rtl/mul64_ap_resp.sv
// ap_ctrl_hs responder: 64x64 -> low 64-bit unsigned multiply, one radix-2 shift-add step per cycle.
// Key-gated lock transitions are dormant when working_key is all zeros.
module mul64_ap_resp #(
    parameter int ITERS = 64
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] ap_return,
    input  logic [63:0] working_key
);

    // state | meaning
    // IDLE  | waiting for ap_start, operands sampled on acceptance
    // CALC  | one shift-add iteration per cycle, ITERS cycles
    // DONE  | one-cycle ap_done/ap_ready, result already on ap_return
    // HOLD  | lock trap, left only through reset
    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        CALC = 4'b0010,
        DONE = 4'b0100,
        HOLD = 4'b1000
    } state_t;

    state_t      r_state;
    logic [63:0] r_acc;
    logic [63:0] r_a_sh;
    logic [63:0] r_b_sh;
    logic [6:0]  r_cnt;
    logic [63:0] r_ret;

    logic        w_lock_skip_calc;
    logic        w_lock_skip_add;
    logic        w_lock_hold;
    logic        w_add;
    logic [63:0] w_acc_nxt;
    logic        w_last;
    logic        w_unused_key;

    assign w_unused_key     = ^working_key[63:3];
    assign w_lock_skip_calc = working_key[0] & (a[1:0] == 2'b11);
    assign w_lock_skip_add  = working_key[1] & (r_b_sh[3:2] == 2'b11);
    assign w_add            = r_b_sh[0] & ~w_lock_skip_add;
    assign w_acc_nxt        = w_add ? (r_acc + r_a_sh) : r_acc;
    assign w_lock_hold      = working_key[2] & (w_acc_nxt[5:4] == 2'b11);
    assign w_last           = (r_cnt == 7'(ITERS - 1));

    assign ap_done   = (r_state == DONE);
    assign ap_ready  = (r_state == DONE);
    assign ap_idle   = (r_state == IDLE) & ~ap_start;
    assign ap_return = r_ret;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_cnt   <= '0;
            r_ret   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ap_start) begin
                        r_a_sh <= a;
                        r_b_sh <= b;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                        if (w_lock_skip_calc) begin
                            r_ret   <= '0;
                            r_state <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_acc  <= w_acc_nxt;
                    r_a_sh <= r_a_sh << 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_cnt  <= r_cnt + 7'd1;
                    if (w_last) begin
                        // HOLD clears the result so every output reads low in the trap
                        if (w_lock_hold) begin
                            r_ret   <= '0;
                            r_state <= HOLD;
                        end else begin
                            r_ret   <= w_acc_nxt;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                HOLD: begin
                    r_state <= HOLD;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul64_ap_resp.sv
// Scoreboard bench for mul64_ap_resp: directed operands, expected result and done cycle queued at issue,
// a negedge monitor pops and compares on every ap_done.
module tb_mul64_ap_resp;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] ap_return;
    logic [63:0] working_key;

    typedef struct {
        logic [63:0] ret;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    mul64_ap_resp dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .ap_ready    (ap_ready),
        .a           (a),
        .b           (b),
        .ap_return   (ap_return),
        .working_key (working_key)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc <= cyc + 1;

    // monitor: every ap_done must match the oldest queued expectation
    always @(negedge ap_clk) begin
        if (ap_done || ap_ready) begin
            checks++;
            if (ap_done !== ap_ready) begin
                errors++;
                $display("FAIL done_ready_pair: done=%0b ready=%0b cyc=%0d", ap_done, ap_ready, cyc);
            end
            if (ap_done) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got done at cyc=%0d, expected none", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checks++;
                    if (ap_return !== e.ret) begin
                        errors++;
                        $display("FAIL result: got %h expected %h", ap_return, e.ret);
                    end
                    checks++;
                    if (cyc != e.cyc) begin
                        errors++;
                        $display("FAIL latency: done at cyc=%0d expected cyc=%0d", cyc, e.cyc);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge ap_clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout: %0d results outstanding after %0d cycles, expected 0", exp_q.size(), n);
            exp_q.delete();
        end
        @(negedge ap_clk);
    endtask

    // called at a negedge; issues a one-cycle start and waits for the response
    task automatic run_op(input logic [63:0] ia, input logic [63:0] ib, input logic [63:0] key,
                          input logic [63:0] exp_ret, input int lat);
        exp_t e;
        a           = ia;
        b           = ib;
        working_key = key;
        ap_start    = 1'b1;
        e.ret = exp_ret;
        e.cyc = cyc + lat;
        exp_q.push_back(e);
        @(negedge ap_clk);
        ap_start = 1'b0;
        drain();
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    initial begin
        int k;
        exp_t e;
        ap_rst_n    = 1'b0;
        ap_start    = 1'b0;
        a           = '0;
        b           = '0;
        working_key = '0;
        repeat (3) @(negedge ap_clk);
        check("reset_return", ap_return, 64'h0);
        check("reset_idle", {63'h0, ap_idle}, 64'h1);
        check("reset_done", {63'h0, ap_done}, 64'h0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        run_op(64'd3, 64'd5, 64'h0, 64'hF, 65);
        repeat (5) @(negedge ap_clk);
        check("hold_in_idle", ap_return, 64'hF);
        check("idle_flag", {63'h0, ap_idle}, 64'h1);

        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run_op(64'h8000_0000_0000_0000, 64'd2, 64'h0, 64'h0, 65);
        run_op(64'h1234_5678, 64'h1_0000, 64'h0, 64'h1234_5678_0000, 65);

        // held start: back-to-back accepts every 66 cycles, operands sampled only at accept
        k           = cyc;
        a           = 64'd7;
        b           = 64'd9;
        working_key = '0;
        ap_start    = 1'b1;
        e.ret = 64'd63; e.cyc = k + 65;  exp_q.push_back(e);
        e.ret = 64'd9;  e.cyc = k + 131; exp_q.push_back(e);
        e.ret = 64'd63; e.cyc = k + 197; exp_q.push_back(e);
        for (int i = 0; i < 133; i++) begin
            @(negedge ap_clk);
            if (cyc == k + 10)  a = 64'd1;
            if (cyc == k + 100) a = 64'd7;
            if (cyc == k + 30)  check("held_idle_calc", {63'h0, ap_idle}, 64'h0);
            if (cyc == k + 66)  check("held_idle_gap", {63'h0, ap_idle}, 64'h0);
        end
        ap_start = 1'b0;
        drain();

        // reset at CALC iteration 30 abandons the op
        k = cyc;
        a        = 64'd3;
        b        = 64'd5;
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        while (cyc < k + 31) @(negedge ap_clk);
        check("pre_reset_return", ap_return, 64'd63);
        do_reset();
        check("mid_reset_idle", {63'h0, ap_idle}, 64'h1);
        check("mid_reset_return", ap_return, 64'h0);
        repeat (80) @(negedge ap_clk);
        run_op(64'd3, 64'd5, 64'h0, 64'hF, 65);

        run_op(64'd3, 64'd5, 64'h1, 64'h0, 1);
        run_op(64'd3, 64'd5, 64'h0, 64'hF, 65);
        run_op(64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFF8, 64'hF, 65);
        run_op(64'd3, 64'hF, 64'h2, 64'd42, 65);
        run_op(64'd3, 64'd5, 64'h4, 64'hF, 65);

        // key bit 2 with acc[5:4]=11 traps in HOLD
        a           = 64'h30;
        b           = 64'd1;
        working_key = 64'h4;
        ap_start    = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        repeat (100) @(negedge ap_clk);
        check("hold_idle", {63'h0, ap_idle}, 64'h0);
        ap_start = 1'b1;
        repeat (3) @(negedge ap_clk);
        check("hold_ignores_start", {63'h0, ap_idle}, 64'h0);
        ap_start = 1'b0;
        do_reset();
        check("hold_reset_idle", {63'h0, ap_idle}, 64'h1);
        run_op(64'd3, 64'd5, 64'h0, 64'hF, 65);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
